// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite sequencer slice.
package sprite_pkg;

  localparam int unsigned H_DISPLAY   = 256;
  localparam int unsigned H_TOTAL     = 309;
  localparam int unsigned V_DISPLAY   = 240;
  localparam int unsigned V_TOTAL     = 262;

  // Bitmap geometry: 16 rows of 8 bits, drawn mirrored to a 16x16 footprint.
  localparam int unsigned SPRITE_H    = 16;
  localparam int unsigned SPRITE_W    = 8;

  localparam logic [8:0] HPOS_LAST    = 9'(H_TOTAL - 1);
  localparam logic [8:0] VPOS_LAST    = 9'(V_TOTAL - 1);
  localparam logic [8:0] VSTART_HPOS  = 9'(H_DISPLAY);
  localparam logic [8:0] LOAD_HPOS    = 9'(H_DISPLAY + 1);

  // Placement bounds keep the whole 16x16 footprint on screen.
  localparam logic [8:0] X_MIN        = 9'd1;
  localparam logic [8:0] X_MAX        = 9'(H_DISPLAY - SPRITE_H);
  localparam logic [8:0] Y_MIN        = 9'd1;
  localparam logic [8:0] Y_MAX        = 9'(V_DISPLAY - SPRITE_H);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    ACTIVE,
    DONE
  } seq_state_t;

  function automatic logic [8:0] clamp9(input logic [8:0] v,
                                        input logic [8:0] lo,
                                        input logic [8:0] hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

endpackage

// File: rtl/sprite_bitmap_ram.sv
// 16x8 sprite bitmap: synchronous write, asynchronous read, cleared by reset.
module sprite_bitmap_ram
  import sprite_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en_i,
  input  logic [3:0]          wr_addr_i,
  input  logic [SPRITE_W-1:0] wr_data_i,
  input  logic [3:0]          rd_addr_i,
  output logic [SPRITE_W-1:0] rd_data_o
);

  logic [SPRITE_W-1:0] mem_q [SPRITE_H];

  // Row storage; a read in the write cycle still sees the old row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SPRITE_H; i++) mem_q[i] <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sprite_sequencer.sv
// Sprite sequencer: strobe generation for sprite_renderer from the beam
// position, plus the CPU-writable bitmap the renderer fetches from.
// Optional feature macro: SPRITE_SEQ_HFLIP_EN (adds hflip input, bit-reverses rom_bits).
module sprite_sequencer
  import sprite_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] hpos,
  input  logic [8:0] vpos,
  input  logic       sprite_en,
  input  logic [8:0] sprite_x,
  input  logic [8:0] sprite_y,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [3:0] rom_addr,
  input  logic       in_progress,
`ifdef SPRITE_SEQ_HFLIP_EN
  input  logic       hflip,
`endif
  output logic [7:0] rom_bits,
  output logic       vstart,
  output logic       load,
  output logic       hstart,
  output logic       overrun
);

  seq_state_t state_q, state_d;
  logic [8:0] act_x_q, act_x_d;
  logic [8:0] act_y_q, act_y_d;
  logic [3:0] line_cnt_q, line_cnt_d;
  logic       vstart_q, vstart_d;
  logic       load_q, load_d;
  logic       hstart_q, hstart_d;
  logic       overrun_q, overrun_d;
  logic [8:0] nh, nv;
  logic       h_wrap, frame_end;
  logic [7:0] ram_bits;

  sprite_bitmap_ram u_ram (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (rom_addr),
    .rd_data_o (ram_bits)
  );

`ifdef SPRITE_SEQ_HFLIP_EN
  logic hflip_q, hflip_d;

  // Mirror flag, latched with the position at frame end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hflip_q <= 1'b0;
    else       hflip_q <= hflip_d;
  end

  // Bit-reverse the fetched row when the active sprite is flipped.
  always_comb begin
    hflip_d = hflip_q;
    if (frame_end && state_q != ACTIVE) hflip_d = hflip;
    rom_bits = hflip_q ? {<<{ram_bits}} : ram_bits;
  end
`else
  assign rom_bits = ram_bits;
`endif

  // Strobes are decoded against the beam position of the next clock so the
  // registered outputs line up with the stated hpos values.
  assign h_wrap    = (hpos == HPOS_LAST);
  assign frame_end = h_wrap && (vpos == VPOS_LAST);
  assign nh        = h_wrap ? '0 : hpos + 9'd1;
  assign nv        = h_wrap ? ((vpos == VPOS_LAST) ? '0 : vpos + 9'd1) : vpos;

  // State, shadow-latched placement, line counter and output strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      act_x_q    <= X_MIN;
      act_y_q    <= Y_MIN;
      line_cnt_q <= '0;
      vstart_q   <= 1'b0;
      load_q     <= 1'b0;
      hstart_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      act_x_q    <= act_x_d;
      act_y_q    <= act_y_d;
      line_cnt_q <= line_cnt_d;
      vstart_q   <= vstart_d;
      load_q     <= load_d;
      hstart_q   <= hstart_d;
      overrun_q  <= overrun_d;
    end
  end

  // Next-state, strobe decode and frame-end latching.
  always_comb begin
    state_d    = state_q;
    act_x_d    = act_x_q;
    act_y_d    = act_y_q;
    line_cnt_d = line_cnt_q;
    overrun_d  = overrun_q;
    vstart_d   = 1'b0;
    load_d     = 1'b0;
    hstart_d   = 1'b0;

    unique case (state_q)
      ARMED: begin
        if (nv == act_y_q - 9'd1 && nh == VSTART_HPOS && !in_progress) begin
          vstart_d = 1'b1;
          state_d  = ACTIVE;
        end
      end
      ACTIVE: begin
        if (nv >= act_y_q - 9'd1 && nv <= act_y_q + 9'd14 && nh >= LOAD_HPOS)
          load_d = 1'b1;
        if (nv >= act_y_q && nv <= act_y_q + 9'd15 && nh == act_x_q) begin
          hstart_d   = 1'b1;
          line_cnt_d = line_cnt_q + 4'd1;
          if (line_cnt_q == 4'd15) state_d = DONE;
        end
      end
      default: ;
    endcase

    // An active sprite keeps its placement; new values wait for the next frame end.
    if (frame_end) begin
      if (in_progress) overrun_d = 1'b1;
      if (state_q != ACTIVE) begin
        act_x_d = clamp9(sprite_x, X_MIN, X_MAX);
        act_y_d = clamp9(sprite_y, Y_MIN, Y_MAX);
        state_d = sprite_en ? ARMED : IDLE;
      end
    end
  end

  assign vstart  = vstart_q;
  assign load    = load_q;
  assign hstart  = hstart_q;
  assign overrun = overrun_q;

endmodule
